// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory request arbiter slice.
package mem_arb_pkg;

    localparam logic REQ_ID_INST = 1'b0;
    localparam logic REQ_ID_DATA = 1'b1;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef struct packed {
        logic id;
        logic discard;
    } req_entry_t;

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_INST = 2'd1,
        LOCK_DATA = 2'd2
    } lock_state_e;

endpackage

// File: rtl/req_id_fifo.sv
// In-order owner tracking FIFO: push/pop, full/empty/count, and a flush-mark-all
// port that sets the discard bit of every valid entry.
module req_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push_i,
    input  req_entry_t       push_entry_i,
    input  logic             pop_i,
    input  logic             mark_all_i,
    output req_entry_t       head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    req_entry_t       mem_q [DEPTH];
    req_entry_t       mem_d [DEPTH];
    logic             push_ok, pop_ok;
    logic [PTR_W-1:0] offset;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        offset   = '0;
        if (mark_all_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                offset = PTR_W'(i) - rd_ptr_q;
                if (CNT_W'(offset) < count_q) begin
                    mem_d[i].discard = 1'b1;
                end
            end
        end
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_entry_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates inst/data ports onto one SRAM-like bus and routes in-order responses.
// Optional MEM_ARB_FLUSH_DISCARD_EN drops responses orphaned by a flush.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_W          = 32
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               inst_req,
    input  logic [ADDR_W-1:0]                  inst_addr,
    input  logic [1:0]                         inst_size,
    output logic                               inst_addr_ok,
    output logic                               inst_data_ok,
    output logic [31:0]                        inst_rdata,
    input  logic                               data_req,
    input  logic                               data_wr,
    input  logic [1:0]                         data_size,
    input  logic [3:0]                         data_wstrb,
    input  logic [ADDR_W-1:0]                  data_addr,
    input  logic [31:0]                        data_wdata,
    output logic                               data_addr_ok,
    output logic                               data_data_ok,
    output logic [31:0]                        data_rdata,
    input  logic                               flush,
    output logic                               bus_req,
    output logic                               bus_wr,
    output logic [1:0]                         bus_size,
    output logic [3:0]                         bus_wstrb,
    output logic [ADDR_W-1:0]                  bus_addr,
    output logic [31:0]                        bus_wdata,
    input  logic                               bus_addr_ok,
    input  logic                               bus_data_ok,
    input  logic [31:0]                        bus_rdata,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               busy
);

    lock_state_e lock_q, lock_d;
    logic        grant_data;
    logic        granted_req;
    logic        fifo_full, fifo_empty;
    logic        mark_all;
    logic        resp_pop, resp_fwd;
    req_entry_t  head;
    req_entry_t  push_entry;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_q <= LOCK_NONE;
        end else begin
            lock_q <= lock_d;
        end
    end

    always_comb begin
        lock_d = lock_q;
        if (flush || (bus_req && bus_addr_ok)) begin
            lock_d = LOCK_NONE;
        end else if (bus_req) begin
            lock_d = grant_data ? LOCK_DATA : LOCK_INST;
        end else if (lock_q != LOCK_NONE && !granted_req) begin
            lock_d = LOCK_NONE;
        end
    end

    always_comb begin
        case (lock_q)
            LOCK_DATA: grant_data = 1'b1;
            LOCK_INST: grant_data = 1'b0;
            default:   grant_data = data_req;
        endcase
        granted_req = grant_data ? data_req : inst_req;
        bus_wr      = 1'b0;
        bus_size    = '0;
        bus_wstrb   = '0;
        bus_addr    = '0;
        bus_wdata   = '0;
        if (granted_req) begin
            if (grant_data) begin
                bus_wr    = data_wr;
                bus_size  = data_size;
                bus_wstrb = data_wstrb;
                bus_addr  = data_addr;
                bus_wdata = data_wdata;
            end else begin
                bus_size  = inst_size;
                bus_addr  = inst_addr;
            end
        end
        bus_req      = granted_req & ~fifo_full & ~flush;
        inst_addr_ok = bus_req & bus_addr_ok & ~grant_data;
        data_addr_ok = bus_req & bus_addr_ok & grant_data;
    end

    assign push_entry = '{id: (grant_data ? REQ_ID_DATA : REQ_ID_INST), discard: 1'b0};
    assign resp_pop   = bus_data_ok & ~fifo_empty;

`ifdef MEM_ARB_FLUSH_DISCARD_EN
    assign mark_all = flush;
    assign resp_fwd = resp_pop & ~head.discard & ~flush;
`else
    // Discard bits are never set here, so every popped response is forwarded.
    assign mark_all = 1'b0;
    assign resp_fwd = resp_pop & ~head.discard;
`endif

    req_id_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_req_id_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (bus_req & bus_addr_ok),
        .push_entry_i(push_entry),
        .pop_i       (bus_data_ok),
        .mark_all_i  (mark_all),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (outstanding)
    );

    assign inst_data_ok = resp_fwd & (head.id == REQ_ID_INST);
    assign data_data_ok = resp_fwd & (head.id == REQ_ID_DATA);
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;
    assign busy         = (outstanding != '0) | (lock_q != LOCK_NONE);

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Shares one SRAM-like memory bus between the instruction-fetch port (IF stage / ICache miss path) and the data port (EX issue, MEM stage completion). It picks one requester per address handshake, holds the grant stable until acceptance, and records each accepted request's owner in an in-order tracking FIFO. It routes each returning `data_ok`/`rdata` to that owner and, optionally, silently drops responses orphaned by a pipeline flush. It sits between the core pipeline and the AXI bridge.

## Interface
Parameters:
- `MAX_OUTSTANDING`, 2 — tracking FIFO depth; power of two, ≥2.
- `ADDR_W`, 32 — address width.

Ports:
- `clk` in 1 — clock.
- `resetn` in 1 — reset: synchronous, active-low.
- `inst_req`, `inst_addr[ADDR_W]`, `inst_size[2]` in — fetch request; always a read.
- `inst_addr_ok`, `inst_data_ok` out 1 — fetch handshakes.
- `inst_rdata` out 32 — fetch return data.
- `data_req`, `data_wr`, `data_size[2]`, `data_wstrb[4]`, `data_addr[ADDR_W]`, `data_wdata[32]` in — load/store request.
- `data_addr_ok`, `data_data_ok` out 1 — data handshakes.
- `data_rdata` out 32 — load return data.
- `flush` in 1 — exception/ertn/refetch flush from WB.
- `bus_req`, `bus_wr`, `bus_size[2]`, `bus_wstrb[4]`, `bus_addr[ADDR_W]`, `bus_wdata[32]` out — downstream request.
- `bus_addr_ok`, `bus_data_ok` in 1 — downstream handshakes.
- `bus_rdata` in 32 — downstream return data.
- `outstanding` out clog2(MAX_OUTSTANDING)+1 — count of accepted, unanswered requests.
- `busy` out 1 — `outstanding != 0 || lock_valid`.

## Operation
- Priority is fixed: data over inst, because data belongs to the older instruction.
- Grant lock:
  - Arbitration happens only when `lock_valid == 0`.
  - If `bus_req & !bus_addr_ok`, register `lock_valid = 1` and `lock_id`.
  - While locked, the grant stays on `lock_id` even if the other port requests.
  - `bus_addr_ok` clears the lock.
  - If the locked requester drops its req, the lock clears next cycle.
- Mux: `bus_*` fields come from the granted port. For an inst grant, `bus_wr = 0` and `bus_wstrb = 0`.
- `bus_req = granted_req & !fifo_full & !flush`.
- Accept: `bus_req & bus_addr_ok` pulses the granted port's `addr_ok` and pushes `{id, discard=0}`. The non-granted port sees `addr_ok = 0`.
- Full FIFO: push is blocked even if a pop happens the same cycle. No bypass.
- Response:
  - `bus_data_ok` pops the head entry.
  - If `discard == 0`, pulse `*_data_ok` of `head.id` and pass `bus_rdata` to both `*_rdata`.
  - If `discard == 1`, no pulse.
  - `bus_data_ok` with an empty FIFO is a protocol error; ignore it and keep the FIFO unchanged.
- Flush:
  - `bus_req` is masked and the lock is cleared in the flush cycle, so no push happens that cycle.
  - Outstanding entries are handled as described under Configuration.
- Responses from the bus are in order; the bus is decided to keep request order.

## Timing
- Request path is combinational, zero latency: `*_req` → `bus_req`, `bus_addr_ok` → `*_addr_ok`.
- Response routing is combinational from the registered FIFO head.
- A push is visible in `outstanding` the next cycle.
- Simultaneous push and pop (not full): count is unchanged, head advances, new entry lands at tail.
- Reset values:
  - Registered: `lock_valid = 0`, `lock_id = 0`, FIFO pointers 0, `outstanding = 0`, all discard bits 0.
  - Combinational outputs settle to 0 when inputs are idle.
- Reset mid-transaction clears all tracking. Bus responses arriving afterwards are ignored as the empty-FIFO error case.

## Configuration
- `MEM_ARB_FLUSH_DISCARD_EN` defined:
  - `flush` sets the discard bit of every valid entry.
  - A `bus_data_ok` in the flush cycle is also suppressed.
  - Discarded responses never reach the pipeline.
- Undefined:
  - No discard bits; every response is forwarded.
  - The MEM stage drop-one-response logic and the IF cancel logic remain responsible for stale data.

## Structure
- Package `mem_arb_pkg`:
  - `REQ_ID_INST = 1'b0`, `REQ_ID_DATA = 1'b1`.
  - Size encodings: `SIZE_B = 0`, `SIZE_H = 1`, `SIZE_W = 2`.
  - Entry typedef `{id, discard}`.
- Sub-module `req_id_fifo`: circular buffer with push/pop/full/empty/count plus a flush-mark-all port.

## Test plan
- Both ports request `data_addr = 0x1c000100`, `inst_addr = 0x1c000000`, with `bus_addr_ok = 1`:
  - Data granted first; inst granted next cycle.
  - Returns `0xAAAA` then `0xBBBB` pulse `data_data_ok` then `inst_data_ok`.
- Inst requests, `bus_addr_ok` held 0 for 3 cycles, data raises req in cycle 2:
  - `bus_addr` stays `inst_addr` until accept.
  - Data is granted afterwards.
- Four back-to-back data reads with `MAX_OUTSTANDING = 2` and no responses:
  - Third request sees `bus_req = 0`, `outstanding = 2`.
  - After one `bus_data_ok`, the third request issues the following cycle.
- With the macro on: two loads outstanding, `flush` pulse, then two `bus_data_ok`:
  - No `data_data_ok` pulses.
  - `outstanding` returns to 0.
  - A new fetch after the flush receives its data normally.
- Same as the previous case with the macro off: both `data_data_ok` pulses appear with `0x11` and `0x22`.
- `resetn = 0` with one entry outstanding:
  - Next cycle `outstanding = 0`, `busy = 0`.
  - A later stray `bus_data_ok` produces no `*_data_ok`.
